// File: rtl/riscv_params_pkg.sv
// Shared core encodings: forwarding-source selects and hazard-controller FSM states.
package riscv_params_pkg;

  typedef enum logic [1:0] {
    FW_RF  = 2'd0,
    FW_EX  = 2'd1,
    FW_MEM = 2'd2,
    FW_WB  = 2'd3
  } fw_sel_e;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_LD_STALL = 2'd1,
    HZ_MC_WAIT  = 2'd2
  } hz_state_e;

endpackage

// File: rtl/hazard_src_cmp.sv
// Per-source operand comparator: picks the youngest forwarding source and flags a load-use hit.
module hazard_src_cmp
  import riscv_params_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic                  src_vld,
  input  logic [ADDR_WIDTH-1:0] ex_rd,
  input  logic [ADDR_WIDTH-1:0] mem_rd,
  input  logic [ADDR_WIDTH-1:0] wb_rd,
  input  logic                  ex_wr,
  input  logic                  mem_wr,
  input  logic                  wb_wr,
  input  logic                  ex_is_ld,
  output logic [1:0]            fw_sel_c,
  output logic                  ld_hit_c
);

  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  assign ex_hit  = src_vld && ex_wr  && (src_addr == ex_rd);
  assign mem_hit = src_vld && mem_wr && (src_addr == mem_rd);
  assign wb_hit  = src_vld && wb_wr  && (src_addr == wb_rd);

  // A load in EX has no data yet, so it never wins; older stages still may.
  always_comb begin
    fw_sel_c = FW_RF;
    if (ex_hit && !ex_is_ld) fw_sel_c = FW_EX;
    else if (mem_hit)        fw_sel_c = FW_MEM;
    else if (wb_hit)         fw_sel_c = FW_WB;
  end

  assign ld_hit_c = ex_hit && ex_is_ld;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage core; combinational controls from registered
// FSM state (RUN, load-use stall, multi-cycle wait) plus current pipeline inputs.
module pipeline_hazard_ctrl
  import riscv_params_pkg::*;
#(
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned LD_STALL   = 1,
  parameter int unsigned MC_TIMEOUT = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC*ADDR_WIDTH-1:0] dec_src_addr,
  input  logic [NUM_SRC-1:0]            dec_src_vld,
  input  logic [ADDR_WIDTH-1:0]         ex_rd,
  input  logic [ADDR_WIDTH-1:0]         mem_rd,
  input  logic [ADDR_WIDTH-1:0]         wb_rd,
  input  logic                          ex_wr,
  input  logic                          mem_wr,
  input  logic                          wb_wr,
  input  logic                          ex_is_ld,
  input  logic                          branch_taken,
  input  logic                          mc_start,
  input  logic                          mc_done,
  output logic                          fetch_en,
  output logic                          decode_en,
  output logic                          execute_en,
  output logic                          mem_en,
  output logic                          flush_dec,
  output logic                          flush_ex,
  output logic [NUM_SRC*2-1:0]          fw_sel,
  output logic [1:0]                    state_o,
  output logic                          err_timeout
);

  localparam int unsigned CNT_W = $clog2(LD_STALL + 1);
  localparam int unsigned TMO_W = (MC_TIMEOUT > 0) ? $clog2(MC_TIMEOUT + 1) : 1;

  hz_state_e          state_q, state_d;
  logic [CNT_W-1:0]   ld_cnt_q, ld_cnt_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic               err_q, err_d;
  logic [NUM_SRC-1:0] ld_hit;
  logic [NUM_SRC*2-1:0] fw_sel_raw;
  logic               ld_use;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    hazard_src_cmp #(.ADDR_WIDTH(ADDR_WIDTH)) u_cmp (
      .src_addr (dec_src_addr[i*ADDR_WIDTH +: ADDR_WIDTH]),
      .src_vld  (dec_src_vld[i]),
      .ex_rd    (ex_rd),
      .mem_rd   (mem_rd),
      .wb_rd    (wb_rd),
      .ex_wr    (ex_wr),
      .mem_wr   (mem_wr),
      .wb_wr    (wb_wr),
      .ex_is_ld (ex_is_ld),
      .fw_sel_c (fw_sel_raw[2*i +: 2]),
      .ld_hit_c (ld_hit[i])
    );
  end

  assign ld_use = |ld_hit;

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= HZ_RUN;
      ld_cnt_q  <= '0;
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ld_cnt_q  <= ld_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end

  // Next state and stage controls; rst > branch > multi-cycle > load-use > run.
  always_comb begin
    state_d    = state_q;
    ld_cnt_d   = ld_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    err_d      = err_q;
    fetch_en   = 1'b1;
    decode_en  = 1'b1;
    execute_en = 1'b1;
    mem_en     = 1'b1;
    flush_dec  = 1'b0;
    flush_ex   = 1'b0;
    if (rst) begin
      fetch_en   = 1'b0;
      decode_en  = 1'b0;
      execute_en = 1'b0;
      mem_en     = 1'b0;
    end else if (branch_taken) begin
      flush_dec = 1'b1;
      flush_ex  = 1'b1;
      state_d   = HZ_RUN;
      ld_cnt_d  = '0;
      tmo_cnt_d = '0;
    end else begin
      case (state_q)
        HZ_RUN: begin
          if (mc_start) begin
            if (!mc_done) begin
              state_d   = HZ_MC_WAIT;
              tmo_cnt_d = '0;
            end
          end else if (ld_use) begin
            fetch_en  = 1'b0;
            decode_en = 1'b0;
            flush_ex  = 1'b1;
            if (LD_STALL > 1) begin
              state_d  = HZ_LD_STALL;
              ld_cnt_d = CNT_W'(LD_STALL - 1);
            end
          end
        end
        HZ_LD_STALL: begin
          fetch_en  = 1'b0;
          decode_en = 1'b0;
          flush_ex  = 1'b1;
          if (ld_cnt_q > CNT_W'(1)) begin
            ld_cnt_d = ld_cnt_q - CNT_W'(1);
          end else begin
            ld_cnt_d = '0;
            state_d  = HZ_RUN;
          end
        end
        HZ_MC_WAIT: begin
          if (mc_done) begin
            state_d   = HZ_RUN;
            tmo_cnt_d = '0;
          end else begin
            fetch_en   = 1'b0;
            decode_en  = 1'b0;
            execute_en = 1'b0;
            mem_en     = 1'b0;
            if (tmo_cnt_q != {TMO_W{1'b1}}) tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            if ((MC_TIMEOUT != 0) && (tmo_cnt_d == TMO_W'(MC_TIMEOUT))) begin
              err_d     = 1'b1;
              state_d   = HZ_RUN;
              tmo_cnt_d = '0;
            end
          end
        end
        default: state_d = HZ_RUN;
      endcase
    end
  end

  assign fw_sel      = rst ? '0 : fw_sel_raw;
  assign state_o     = rst ? 2'b00 : 2'(state_q);
  assign err_timeout = err_q && !rst;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: instance a (LD_STALL=2, MC_TIMEOUT=4) and
// instance b (LD_STALL=2, MC_TIMEOUT=64) share stimulus.
module tb_pipeline_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] dec_src_addr;
  logic [1:0] dec_src_vld;
  logic [3:0] ex_rd, mem_rd, wb_rd;
  logic       ex_wr, mem_wr, wb_wr, ex_is_ld;
  logic       branch_taken, mc_start, mc_done;

  logic [3:0] a_en, b_en;
  logic [1:0] a_fl, b_fl;
  logic [3:0] a_fw, b_fw;
  logic [1:0] a_state, b_state;
  logic       a_err, b_err;

  int n_vec;
  int n_err;

  pipeline_hazard_ctrl #(.NUM_SRC(2), .ADDR_WIDTH(4), .LD_STALL(2), .MC_TIMEOUT(4)) dut_a (
    .clk(clk), .rst(rst), .dec_src_addr(dec_src_addr), .dec_src_vld(dec_src_vld),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd), .ex_wr(ex_wr), .mem_wr(mem_wr),
    .wb_wr(wb_wr), .ex_is_ld(ex_is_ld), .branch_taken(branch_taken), .mc_start(mc_start),
    .mc_done(mc_done), .fetch_en(a_en[3]), .decode_en(a_en[2]), .execute_en(a_en[1]),
    .mem_en(a_en[0]), .flush_dec(a_fl[1]), .flush_ex(a_fl[0]), .fw_sel(a_fw),
    .state_o(a_state), .err_timeout(a_err)
  );

  pipeline_hazard_ctrl #(.NUM_SRC(2), .ADDR_WIDTH(4), .LD_STALL(2), .MC_TIMEOUT(64)) dut_b (
    .clk(clk), .rst(rst), .dec_src_addr(dec_src_addr), .dec_src_vld(dec_src_vld),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd), .ex_wr(ex_wr), .mem_wr(mem_wr),
    .wb_wr(wb_wr), .ex_is_ld(ex_is_ld), .branch_taken(branch_taken), .mc_start(mc_start),
    .mc_done(mc_done), .fetch_en(b_en[3]), .decode_en(b_en[2]), .execute_en(b_en[1]),
    .mem_en(b_en[0]), .flush_dec(b_fl[1]), .flush_ex(b_fl[0]), .fw_sel(b_fw),
    .state_o(b_state), .err_timeout(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    dec_src_addr = '0; dec_src_vld = '0;
    ex_rd = '0; mem_rd = '0; wb_rd = '0;
    ex_wr = 1'b0; mem_wr = 1'b0; wb_wr = 1'b0; ex_is_ld = 1'b0;
    branch_taken = 1'b0; mc_start = 1'b0; mc_done = 1'b0;
  endtask

  task automatic set_load_use();
    clear_inputs();
    ex_rd = 4'd5; ex_wr = 1'b1; ex_is_ld = 1'b1;
    dec_src_addr = {4'd5, 4'd0}; dec_src_vld = 2'b10;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    clear_inputs();
    rst = 1'b1;
    // Busy inputs during reset: outputs must still read 0.
    branch_taken = 1'b1; mc_start = 1'b1; dec_src_vld = 2'b11;
    dec_src_addr = {4'd3, 4'd3}; ex_rd = 4'd3; ex_wr = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_en", 8'(a_en), 8'h00);
      chk("rst_flush", 8'(a_fl), 8'h00);
      chk("rst_fw", 8'(a_fw), 8'h00);
      chk("rst_state", 8'(a_state), 8'h00);
      chk("rst_err", 8'(a_err), 8'h00);
    end
    next_cyc(); clear_inputs(); rst = 1'b0;
    @(negedge clk);
    chk("post_rst_en", 8'(a_en), 8'h0F);
    chk("post_rst_fw", 8'(a_fw), 8'h00);
    chk("post_rst_en_b", 8'(b_en), 8'h0F);

    // Forwarding priority on src0
    next_cyc();
    dec_src_addr = {4'd0, 4'd3}; dec_src_vld = 2'b01;
    ex_rd = 4'd3; mem_rd = 4'd3; wb_rd = 4'd3; ex_wr = 1'b1; mem_wr = 1'b1; wb_wr = 1'b1;
    @(negedge clk);
    chk("fw_ex", 8'(a_fw), 8'h01);
    chk("fw_ex_en", 8'(a_en), 8'h0F);
    next_cyc(); ex_wr = 1'b0;
    @(negedge clk); chk("fw_mem", 8'(a_fw), 8'h02);
    next_cyc(); mem_wr = 1'b0;
    @(negedge clk); chk("fw_wb", 8'(a_fw), 8'h03);
    next_cyc(); wb_wr = 1'b0;
    @(negedge clk); chk("fw_rf", 8'(a_fw), 8'h00);
    // Two sources: src0 from MEM, src1 from EX; then src1 invalid
    next_cyc();
    dec_src_addr = {4'd7, 4'd3}; dec_src_vld = 2'b11;
    ex_rd = 4'd7; ex_wr = 1'b1; mem_rd = 4'd3; mem_wr = 1'b1;
    @(negedge clk); chk("fw_two_src", 8'(a_fw), 8'h06);
    next_cyc(); dec_src_vld = 2'b01;
    @(negedge clk); chk("fw_src1_invalid", 8'(a_fw), 8'h02);

    // Load-use, LD_STALL=2; MEM also holds r5 so src1 must pick MEM, not the load
    next_cyc(); set_load_use(); mem_rd = 4'd5; mem_wr = 1'b1;
    @(negedge clk);
    chk("ld_c0_en", 8'(a_en), 8'h03);
    chk("ld_c0_flush", 8'(a_fl), 8'h01);
    chk("ld_c0_fw", 8'(a_fw), 8'h08);
    chk("ld_c0_state", 8'(a_state), 8'h00);
    next_cyc(); clear_inputs();
    @(negedge clk);
    chk("ld_c1_state", 8'(a_state), 8'h01);
    chk("ld_c1_en", 8'(a_en), 8'h03);
    chk("ld_c1_flush", 8'(a_fl), 8'h01);
    next_cyc();
    @(negedge clk);
    chk("ld_done_state", 8'(a_state), 8'h00);
    chk("ld_done_en", 8'(a_en), 8'h0F);
    chk("ld_done_flush", 8'(a_fl), 8'h00);

    // Branch taken while in LD_STALL
    next_cyc(); set_load_use();
    @(negedge clk); chk("br_ld_en", 8'(a_en), 8'h03);
    next_cyc(); branch_taken = 1'b1;
    @(negedge clk);
    chk("br_stall_state", 8'(a_state), 8'h01);
    chk("br_stall_en", 8'(a_en), 8'h0F);
    chk("br_stall_flush", 8'(a_fl), 8'h03);
    next_cyc(); clear_inputs();
    @(negedge clk);
    chk("br_after_state", 8'(a_state), 8'h00);
    chk("br_after_en", 8'(a_en), 8'h0F);
    chk("br_after_flush", 8'(a_fl), 8'h00);
    // Branch and load-use together in RUN: hazard discarded
    next_cyc(); set_load_use(); branch_taken = 1'b1;
    @(negedge clk);
    chk("br_ld_same_en", 8'(a_en), 8'h0F);
    chk("br_ld_same_flush", 8'(a_fl), 8'h03);
    next_cyc(); clear_inputs();
    @(negedge clk); chk("br_ld_same_next", 8'(a_state), 8'h00);

    // Multi-cycle op: b sees done after 5 wait cycles, a times out after 4
    next_cyc(); mc_start = 1'b1;
    @(negedge clk);
    chk("mc_start_en_a", 8'(a_en), 8'h0F);
    chk("mc_start_en_b", 8'(b_en), 8'h0F);
    next_cyc(); mc_start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk("mc_wait_en_b", 8'(b_en), 8'h00);
      chk("mc_wait_state_b", 8'(b_state), 8'h02);
      if (i <= 4) begin
        chk("tmo_wait_en_a", 8'(a_en), 8'h00);
        chk("tmo_wait_err_a", 8'(a_err), 8'h00);
        chk("tmo_wait_state_a", 8'(a_state), 8'h02);
      end else begin
        chk("tmo_err_a", 8'(a_err), 8'h01);
        chk("tmo_state_a", 8'(a_state), 8'h00);
        chk("tmo_en_a", 8'(a_en), 8'h0F);
      end
      if (i < 5) next_cyc();
    end
    next_cyc(); mc_done = 1'b1;
    @(negedge clk);
    chk("mc_done_en_b", 8'(b_en), 8'h0F);
    chk("mc_done_state_b", 8'(b_state), 8'h02);
    next_cyc(); mc_done = 1'b0;
    @(negedge clk);
    chk("mc_after_state_b", 8'(b_state), 8'h00);
    chk("mc_after_err_b", 8'(b_err), 8'h00);
    chk("tmo_sticky_a", 8'(a_err), 8'h01);

    // mc_start with mc_done in the same cycle: no stall
    next_cyc(); mc_start = 1'b1; mc_done = 1'b1;
    @(negedge clk); chk("mc_same_en", 8'(b_en), 8'h0F);
    next_cyc(); clear_inputs();
    @(negedge clk);
    chk("mc_same_state", 8'(b_state), 8'h00);
    chk("mc_same_en_next", 8'(b_en), 8'h0F);
    chk("tmo_sticky_a2", 8'(a_err), 8'h01);

    // Reset in the middle of MC_WAIT
    next_cyc(); mc_start = 1'b1;
    next_cyc(); mc_start = 1'b0;
    @(negedge clk);
    chk("rst_mid_state", 8'(b_state), 8'h02);
    chk("rst_mid_en", 8'(b_en), 8'h00);
    next_cyc(); rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_en_a", 8'(a_en), 8'h00);
    chk("rst_mid_err_a", 8'(a_err), 8'h00);
    next_cyc(); rst = 1'b0;
    @(negedge clk);
    chk("rst_rel_en_a", 8'(a_en), 8'h0F);
    chk("rst_rel_state_a", 8'(a_state), 8'h00);
    chk("rst_rel_err_a", 8'(a_err), 8'h00);
    chk("rst_rel_state_b", 8'(b_state), 8'h00);
    chk("rst_rel_en_b", 8'(b_en), 8'h0F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
